// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-requester load/inc register arbiter:
// FSM state encoding and operation codes.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_INC  = 1'b1;

endpackage

// File: rtl/reg_arbiter_if.sv
// Requester and register-side signals of reg_arbiter. The slave modport is the
// arbiter; the master modport is the environment (requesters plus register).
interface reg_arb_if #(parameter int WIDTH = 8);

    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_data_in;
    logic             reg_load;
    logic             reg_inc;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport slave (
        input  req0, req1, op0, op1, data0, data1, reg_q,
        output reg_data_in, reg_load, reg_inc, ack0, ack1, rdata, busy
    );

    modport master (
        output req0, req1, op0, op1, data0, data1, reg_q,
        input  reg_data_in, reg_load, reg_inc, ack0, ack1, rdata, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Stateless two-way round-robin pick: a sole requester wins, a tie goes to
// the requester that was not granted last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic valid
);

    assign valid = req0 | req1;
    assign grant = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates two requesters onto one load/inc register. Each transaction runs
// IDLE -> ISSUE (strobe) -> RESP (ack + readback); outputs decode state only.
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      sync_nreset,
    reg_arb_if.slave  bus
);

    state_e           state_q, state_d;
    logic             id_q, id_d;
    logic             op_q, op_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pick_id;
    logic             pick_vld;

    rr_pick2 u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last_q),
        .grant (pick_id),
        .valid (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        op_d    = op_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_ISSUE;
                    id_d    = pick_id;
                    op_d    = pick_id ? bus.op1   : bus.op0;
                    data_d  = pick_id ? bus.data1 : bus.data0;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = id_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            op_q    <= op_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        bus.busy        = (state_q != ST_IDLE);
        bus.reg_load    = (state_q == ST_ISSUE) && (op_q == OP_LOAD);
        bus.reg_inc     = (state_q == ST_ISSUE) && (op_q == OP_INC);
        bus.reg_data_in = data_q;
        bus.ack0        = (state_q == ST_RESP) && !id_q;
        bus.ack1        = (state_q == ST_RESP) && id_q;
        bus.rdata       = (state_q == ST_RESP) ? bus.reg_q : '0;
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Randomized + directed bench for reg_arbiter driving a load/inc register;
// a transaction-level reference model feeds a scoreboard checked per cycle.
module tb_reg_arbiter;
    import reg_arb_pkg::*;

    typedef struct {
        int         id;
        logic       op;
        logic [7:0] data;
        int         t0;
        logic [7:0] rdata;
    } tx_t;

    typedef struct {
        int         id;
        logic [7:0] rd;
        int         e;
    } ack_t;

    logic       clk = 1'b0;
    logic       sync_nreset = 1'b0;
    logic       reg_rst_n = 1'b0;
    logic [7:0] reg_val;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    reg_arb_if #(.WIDTH(8)) bus ();

    reg_arbiter #(.WIDTH(8)) dut (
        .clk         (clk),
        .sync_nreset (sync_nreset),
        .bus         (bus.slave)
    );

    // The controlled load/inc register, with its own reset.
    always @(posedge clk) begin
        if (!reg_rst_n)        reg_val <= 8'h00;
        else if (bus.reg_load) reg_val <= bus.reg_data_in;
        else if (bus.reg_inc)  reg_val <= reg_val + 8'd1;
    end
    assign bus.reg_q = reg_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request sampled at an edge when the arbiter is free
    // occupies that edge plus the next two; the register applies the op one
    // edge after sampling and the ack reports that new value.
    int         edge_n = 0;
    int         next_free = 0;
    int         last_g = 1;
    logic [7:0] mreg = 8'h00;
    logic [7:0] last_data = 8'h00;
    tx_t        q[$];
    ack_t       seen[$];
    bit         mon_on = 1'b0;

    always @(posedge clk) begin : model
        tx_t t;
        int  w;
        edge_n++;
        if (!reg_rst_n) mreg = 8'h00;
        else foreach (q[i]) if (q[i].t0 == edge_n - 1) begin
            mreg = (q[i].op == OP_INC) ? mreg + 8'd1 : q[i].data;
            q[i].rdata = mreg;
        end
        if (!sync_nreset) begin
            q.delete();
            next_free = edge_n + 1;
            last_g    = 1;
            last_data = 8'h00;
            mon_on    = 1'b1;
        end else if (edge_n >= next_free && (bus.req0 || bus.req1)) begin
            w = (bus.req0 && bus.req1) ? 1 - last_g : (bus.req1 ? 1 : 0);
            t.id    = w;
            t.op    = w ? bus.op1 : bus.op0;
            t.data  = w ? bus.data1 : bus.data0;
            t.t0    = edge_n;
            t.rdata = 8'h00;
            q.push_back(t);
            last_g    = w;
            last_data = t.data;
            next_free = edge_n + 3;
        end
    end

    always @(negedge clk) begin : monitor
        int   si;
        int   ai;
        ack_t a;
        if (mon_on) begin
            si = -1;
            ai = -1;
            foreach (q[i]) begin
                if (q[i].t0 == edge_n)     si = i;
                if (q[i].t0 == edge_n - 1) ai = i;
            end
            if (si >= 0) begin
                chk("reg_load", bus.reg_load, q[si].op == OP_LOAD);
                chk("reg_inc", bus.reg_inc, q[si].op == OP_INC);
                chk("reg_data_in", bus.reg_data_in, q[si].data);
            end else begin
                chk("reg_load_idle", bus.reg_load, 0);
                chk("reg_inc_idle", bus.reg_inc, 0);
                chk("reg_data_in_hold", bus.reg_data_in, last_data);
            end
            if (bus.ack0 || bus.ack1) begin
                a.id = bus.ack1 ? 1 : 0;
                a.rd = bus.rdata;
                a.e  = edge_n;
                seen.push_back(a);
            end
            if (ai >= 0) begin
                chk("ack0", bus.ack0, q[ai].id == 0);
                chk("ack1", bus.ack1, q[ai].id == 1);
                chk("rdata", bus.rdata, q[ai].rdata);
                q.delete(ai);
            end else begin
                chk("ack0_idle", bus.ack0, 0);
                chk("ack1_idle", bus.ack1, 0);
                chk("rdata_idle", bus.rdata, 0);
            end
            chk("busy", bus.busy, (si >= 0) || (ai >= 0));
            chk("strobe_excl", bus.reg_load & bus.reg_inc, 0);
            chk("ack_excl", bus.ack0 & bus.ack1, 0);
        end
    end

    function automatic bit hit(input int which);
        case (which)
            0:       return bus.ack0;
            1:       return bus.ack1;
            2:       return bus.reg_load | bus.reg_inc;
            default: return bus.ack0 | bus.ack1;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hit(which)) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL timeout_%s: got no event expected event within 20 cycles", nm);
    endtask

    task automatic drive(input int who, input bit rq, input logic op, input logic [7:0] d);
        if (who == 0) begin bus.req0 = rq; bus.op0 = op; bus.data0 = d; end
        else          begin bus.req1 = rq; bus.op1 = op; bus.data1 = d; end
    endtask

    task automatic do_txn(input int who, input logic op, input logic [7:0] d);
        drive(who, 1'b1, op, d);
        wait_for(who, "ack");
        drive(who, 1'b0, op, d);
        @(negedge clk);
    endtask

    initial begin : stim
        int n0;
        int cnt;
        bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
        bus.data0 = 0; bus.data1 = 0;
        repeat (3) @(negedge clk);
        reg_rst_n   = 1'b1;
        sync_nreset = 1'b1;

        // Sole requester 0 loads 0x5A.
        do_txn(0, OP_LOAD, 8'h5A);
        chk("t1_ack_id", seen[$].id, 0);
        chk("t1_rdata", seen[$].rd, 8'h5A);
        chk("t1_reg", reg_val, 8'h5A);

        // Continuous INC from both, register starting at 0x00.
        do_txn(1, OP_LOAD, 8'h00);
        n0 = seen.size();
        drive(0, 1'b1, OP_INC, 8'h00);
        drive(1, 1'b1, OP_INC, 8'h00);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 4; k++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) cnt++;
        end
        drive(0, 1'b0, OP_INC, 8'h00);
        drive(1, 1'b0, OP_INC, 8'h00);
        @(negedge clk);
        chk("t2_ack_count", seen.size() - n0, 4);
        if (seen.size() - n0 >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_grant", seen[n0+i].id, i % 2);
                chk("t2_rdata", seen[n0+i].rd, i + 1);
                if (i > 0) chk("t2_spacing", seen[n0+i].e - seen[n0+i-1].e, 3);
            end
        end

        // INC wraps at all-ones.
        do_txn(1, OP_LOAD, 8'hFF);
        do_txn(1, OP_INC, 8'h00);
        chk("t3_ack_id", seen[$].id, 1);
        chk("t3_wrap", seen[$].rd, 8'h00);

        // Inputs changed and req dropped during ISSUE have no effect.
        drive(0, 1'b1, OP_LOAD, 8'h11);
        wait_for(2, "strobe");
        drive(0, 1'b0, OP_INC, 8'h22);
        wait_for(0, "ack");
        @(negedge clk);
        chk("t4_reg", reg_val, 8'h11);
        chk("t4_rdata", seen[$].rd, 8'h11);

        // Reset during ISSUE aborts; requester 0 then wins the tie.
        drive(1, 1'b1, OP_LOAD, 8'h33);
        wait_for(2, "strobe");
        sync_nreset = 1'b0;
        drive(1, 1'b0, OP_LOAD, 8'h33);
        @(negedge clk);
        chk("t5_busy", bus.busy, 0);
        chk("t5_no_ack", bus.ack0 | bus.ack1, 0);
        sync_nreset = 1'b1;
        repeat (3) @(negedge clk);
        drive(0, 1'b1, OP_LOAD, 8'h44);
        drive(1, 1'b1, OP_LOAD, 8'h55);
        wait_for(3, "tie_ack");
        chk("t5_tie_winner0", bus.ack0, 1);
        drive(0, 1'b0, OP_LOAD, 8'h44);
        wait_for(1, "ack1");
        drive(1, 1'b0, OP_LOAD, 8'h55);
        @(negedge clk);
        chk("t5_rdata1", seen[$].rd, 8'h55);

        // Random traffic; a req held past its ack is a new request.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((bus.req0 && bus.ack0) || !bus.req0)
                drive(0, ($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom));
            if ((bus.req1 && bus.ack1) || !bus.req1)
                drive(1, ($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom));
        end
        for (int k = 0; k < 30 && (bus.req0 || bus.req1); k++) begin
            @(negedge clk);
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        chk("reg_final", reg_val, mreg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
